// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WD byte header from each AXI-Stream packet onto a side channel and
// realigns the payload to beat boundaries. Optional keep/packet checker: AXIS_EXTRACT_HDR_CHECK_EN.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic [BYTE_CNT_WD-1:0]  hdr_len,
    output logic                    valid_hdr,
    input  logic                    ready_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out
`ifdef AXIS_EXTRACT_HDR_CHECK_EN
    ,
    output logic                    err
`endif
);

    // state | meaning
    // IDLE  | waiting for the first (header) beat of a packet
    // BODY  | realigning payload beats, residual carried between beats
    // FLUSH | emitting the residual left over after the last input beat
    typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

    localparam int CNT_WD = BYTE_CNT_WD + 1;
    localparam int TOT_WD = CNT_WD + 1;

    function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [CNT_WD-1:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    function automatic logic [CNT_WD-1:0] pop_cnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [CNT_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_WD'(k[i]);
        return c;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [CNT_WD-1:0]       res_cnt_q, res_cnt_d;
    logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    valid_hdr_q, valid_hdr_d;
    logic [DATA_WD-1:0]      data_hdr_q, data_hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;

    logic                    accept, out_free, overflow, hdr_only;
    logic [DATA_WD-1:0]      data_m;
    logic [CNT_WD-1:0]       k_in, s_in;
    logic [TOT_WD-1:0]       total;
    logic [2*DATA_WD-1:0]    cat;
    logic [DATA_BYTE_WD-1:0] hdr_keep;

    assign out_free = !valid_out_q || ready_out;
    assign ready_in = (state_q != FLUSH) && out_free &&
                      (state_q != IDLE || !valid_hdr_q || ready_hdr);
    assign accept   = valid_in && ready_in;
    assign data_m   = data_in & byte_mask(keep_in);
    assign k_in     = pop_cnt(keep_in);
    assign s_in     = CNT_WD'(hdr_len) + CNT_WD'(1);
    // Residual bytes followed by the new beat; upper half is the next output, lower half the carry.
    assign cat      = {res_q, {DATA_WD{1'b0}}} | ({data_m, {DATA_WD{1'b0}}} >> {res_cnt_q, 3'b000});
    assign total    = TOT_WD'(res_cnt_q) + TOT_WD'(k_in);
    assign overflow = total > TOT_WD'(DATA_BYTE_WD);
    assign hdr_only = last_in && (k_in <= s_in);
    assign hdr_keep = hdr_only ? keep_in : top_mask(s_in);

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        valid_out_d = valid_out_q && !ready_out;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        valid_hdr_d = valid_hdr_q && !ready_hdr;
        data_hdr_d  = data_hdr_q;
        keep_hdr_d  = keep_hdr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    valid_hdr_d = 1'b1;
                    keep_hdr_d  = hdr_keep;
                    data_hdr_d  = data_m & byte_mask(hdr_keep);
                    res_d       = '0;
                    res_cnt_d   = '0;
                    if (!hdr_only) begin
                        if (last_in) begin
                            valid_out_d = 1'b1;
                            data_out_d  = data_m << {s_in, 3'b000};
                            keep_out_d  = top_mask(k_in - s_in);
                            last_out_d  = 1'b1;
                        end else begin
                            res_d     = data_m << {s_in, 3'b000};
                            res_cnt_d = k_in - s_in;
                            state_d   = BODY;
                        end
                    end
                end
            end
            BODY: begin
                if (accept) begin
                    valid_out_d = 1'b1;
                    data_out_d  = cat[2*DATA_WD-1:DATA_WD];
                    if (last_in && !overflow) begin
                        keep_out_d = top_mask(total[CNT_WD-1:0]);
                        last_out_d = 1'b1;
                        res_d      = '0;
                        res_cnt_d  = '0;
                        state_d    = IDLE;
                    end else begin
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                        res_d      = cat[DATA_WD-1:0];
                        res_cnt_d  = overflow ? CNT_WD'(total - TOT_WD'(DATA_BYTE_WD)) : '0;
                        if (last_in) state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_q;
                    keep_out_d  = top_mask(res_cnt_q);
                    last_out_d  = 1'b1;
                    res_d       = '0;
                    res_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_q       <= '0;
            res_cnt_q   <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            valid_hdr_q <= 1'b0;
            data_hdr_q  <= '0;
            keep_hdr_q  <= '0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            valid_hdr_q <= valid_hdr_d;
            data_hdr_q  <= data_hdr_d;
            keep_hdr_q  <= keep_hdr_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;
    assign valid_hdr = valid_hdr_q;
    assign data_hdr  = data_hdr_q;
    assign keep_hdr  = keep_hdr_q;

`ifdef AXIS_EXTRACT_HDR_CHECK_EN
    logic err_q, err_d;

    // Flags holes in keep, short non-last beats, and packets with no payload at all.
    always_comb begin
        err_d = 1'b0;
        if (accept)
            err_d = (keep_in != top_mask(k_in)) || (!last_in && keep_in != '1) ||
                    (state_q == IDLE && hdr_only);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed table vectors, backpressure/reset sequences and a random byte-level scoreboard
// for axi_stream_extract_header (32-bit data).
module tb_axi_stream_extract_header;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, ready_in, last_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic [1:0]  hdr_len;
    logic        valid_hdr, valid_out, last_out;
    logic        ready_hdr = 1'b1, ready_out = 1'b1;
    logic [31:0] data_hdr, data_out;
    logic [3:0]  keep_hdr, keep_out;
`ifdef AXIS_EXTRACT_HDR_CHECK_EN
    logic        err;
    int          err_cnt = 0;
`endif

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .hdr_len(hdr_len),
        .valid_hdr(valid_hdr), .ready_hdr(ready_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out),
        .last_out(last_out)
`ifdef AXIS_EXTRACT_HDR_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       hl;
        int               nb;
        logic [3:0][31:0] d;
        logic [3:0][3:0]  k;
        logic [31:0]      hd;
        logic [3:0]       hk;
        int               np;
        logic [3:0][31:0] pd;
        logic [3:0][3:0]  pk;
        int               err;
    } vec_t;

    localparam int NV = 9;
    vec_t vt[NV];

    int          n_cmp = 0, n_err = 0, n_pay = 0;
    int          bp_mode = 0;
    logic        ignore = 1'b0;
    logic [36:0] exp_pay[$];
    logic [35:0] exp_hdr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // 0: always ready, 1: random, 2: both stalled, 3: payload stalled only
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1:       begin ready_out = 1'($urandom_range(0, 1)); ready_hdr = 1'($urandom_range(0, 1)); end
            2:       begin ready_out = 1'b0; ready_hdr = 1'b0; end
            3:       begin ready_out = 1'b0; ready_hdr = 1'b1; end
            default: begin ready_out = 1'b1; ready_hdr = 1'b1; end
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && !ignore) begin
            if (valid_out && ready_out) begin
                n_pay++;
                if (exp_pay.size() == 0) chk("unexpected payload beat", {data_out, keep_out, last_out}, '0);
                else chk("payload beat", {data_out, keep_out, last_out}, exp_pay.pop_front());
            end
            if (valid_hdr && ready_hdr) begin
                if (exp_hdr.size() == 0) chk("unexpected header", {data_hdr, keep_hdr}, '0);
                else chk("header", {data_hdr, keep_hdr}, exp_hdr.pop_front());
            end
        end
`ifdef AXIS_EXTRACT_HDR_CHECK_EN
        if (err) err_cnt++;
`endif
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] hl);
        int n = 0;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; hdr_len = hl;
        @(negedge clk);
        while (!ready_in && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) begin
            n_cmp++; n_err++;
            $display("FAIL send_beat timeout: ready_in %b, required 1", ready_in);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_vec(input vec_t v);
        for (int b = 0; b < v.nb; b++) send_beat(v.d[b], v.k[b], b == v.nb - 1, v.hl);
    endtask

    task automatic push_vec(input vec_t v);
        exp_hdr.push_back({v.hd, v.hk});
        for (int j = 0; j < v.np; j++) exp_pay.push_back({v.pd[j], v.pk[j], j == v.np - 1});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, " outstanding beats"}, 64'(exp_pay.size() + exp_hdr.size()), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int p0 = n_pay;
`ifdef AXIS_EXTRACT_HDR_CHECK_EN
        int e0 = err_cnt;
`endif
        push_vec(v);
        send_vec(v);
        wait_drain($sformatf("vec%0d", idx));
        chk($sformatf("vec%0d payload beat count", idx), 64'(n_pay - p0), 64'(v.np));
`ifdef AXIS_EXTRACT_HDR_CHECK_EN
        chk($sformatf("vec%0d err pulses", idx), 64'(err_cnt - e0), 64'(v.err));
`endif
    endtask

    task automatic rand_pkt();
        int          len, s, nb, hs, p;
        logic [1:0]  hl;
        logic [7:0]  b[12];
        logic [31:0] w;
        logic [3:0]  k;
        len = $urandom_range(1, 12);
        hl  = 2'($urandom_range(0, 3));
        s   = int'(hl) + 1;
        nb  = (len + 3) / 4;
        for (int i = 0; i < len; i++) b[i] = 8'($urandom);
        hs = (len < s) ? len : s;
        w = '0; k = '0;
        for (int i = 0; i < hs; i++) begin
            w[31-8*i -: 8] = b[i];
            k[3-i] = 1'b1;
        end
        exp_hdr.push_back({w, k});
        p = len - s;
        for (int j = 0; j < p; j += 4) begin
            w = '0; k = '0;
            for (int m = 0; m < 4 && j + m < p; m++) begin
                w[31-8*m -: 8] = b[s+j+m];
                k[3-m] = 1'b1;
            end
            exp_pay.push_back({w, k, j + 4 >= p});
        end
        for (int bi = 0; bi < nb; bi++) begin
            w = $urandom; k = '0;
            for (int m = 0; m < 4; m++)
                if (bi * 4 + m < len) begin
                    w[31-8*m -: 8] = b[bi*4+m];
                    k[3-m] = 1'b1;
                end
            send_beat(w, k, bi == nb - 1, (bi == 0) ? hl : 2'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; hdr_len = '0;

        vt[0] = '{hl: 2'd1, nb: 3, d: {32'h0, 32'h55667788, 32'h11223344, 32'hAABBCCDD}, k: {4'h0, 4'hF, 4'hF, 4'hF},
                  hd: 32'hAABB0000, hk: 4'hC, np: 3, pd: {32'h0, 32'h77880000, 32'h33445566, 32'hCCDD1122},
                  pk: {4'h0, 4'hC, 4'hF, 4'hF}, err: 0};
        vt[1] = '{hl: 2'd2, nb: 3, d: {32'h0, 32'h090A0B00, 32'h05060708, 32'h01020304}, k: {4'h0, 4'hE, 4'hF, 4'hF},
                  hd: 32'h01020300, hk: 4'hE, np: 2, pd: {32'h0, 32'h0, 32'h08090A0B, 32'h04050607},
                  pk: {4'h0, 4'h0, 4'hF, 4'hF}, err: 0};
        vt[2] = '{hl: 2'd2, nb: 3, d: {32'h0, 32'h090A0B0C, 32'h05060708, 32'h01020304}, k: {4'h0, 4'hF, 4'hF, 4'hF},
                  hd: 32'h01020300, hk: 4'hE, np: 3, pd: {32'h0, 32'h0C000000, 32'h08090A0B, 32'h04050607},
                  pk: {4'h0, 4'h8, 4'hF, 4'hF}, err: 0};
        vt[3] = '{hl: 2'd3, nb: 3, d: {32'h0, 32'hC0C1C2FF, 32'hB0B1B2B3, 32'hA0A1A2A3}, k: {4'h0, 4'hE, 4'hF, 4'hF},
                  hd: 32'hA0A1A2A3, hk: 4'hF, np: 2, pd: {32'h0, 32'h0, 32'hC0C1C200, 32'hB0B1B2B3},
                  pk: {4'h0, 4'h0, 4'hE, 4'hF}, err: 0};
        vt[4] = '{hl: 2'd1, nb: 1, d: {96'h0, 32'hDEADBEEF}, k: {12'h0, 4'hC},
                  hd: 32'hDEAD0000, hk: 4'hC, np: 0, pd: '0, pk: '0, err: 1};
        vt[5] = '{hl: 2'd0, nb: 1, d: {96'h0, 32'h12345678}, k: {12'h0, 4'hF},
                  hd: 32'h12000000, hk: 4'h8, np: 1, pd: {96'h0, 32'h34567800}, pk: {12'h0, 4'hE}, err: 0};
        vt[6] = '{hl: 2'd0, nb: 2, d: {64'h0, 32'h9ABCDEF0, 32'h12345678}, k: {8'h0, 4'h8, 4'hF},
                  hd: 32'h12000000, hk: 4'h8, np: 1, pd: {96'h0, 32'h3456789A}, pk: {12'h0, 4'hF}, err: 0};
        vt[7] = '{hl: 2'd2, nb: 1, d: {96'h0, 32'h0102030F}, k: {12'h0, 4'hE},
                  hd: 32'h01020300, hk: 4'hE, np: 0, pd: '0, pk: '0, err: 1};
        vt[8] = '{hl: 2'd3, nb: 1, d: {96'h0, 32'h11223344}, k: {12'h0, 4'hF},
                  hd: 32'h11223344, hk: 4'hF, np: 0, pd: '0, pk: '0, err: 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid_out", valid_out, 0);
        chk("reset valid_hdr", valid_hdr, 0);
        chk("reset data/keep/last out", {data_out, keep_out, last_out}, 0);
        chk("reset data/keep hdr", {data_hdr, keep_hdr}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("ready_in after reset", ready_in, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_vec(vt[i], i);

        // payload stalled: output beat must hold steady
        bp_mode = 3;
        push_vec(vt[0]);
        fork
            send_vec(vt[0]);
        join_none
        repeat (6) @(negedge clk);
        chk("hold valid_out", valid_out, 1);
        chk("hold beat", {data_out, keep_out, last_out}, {32'hCCDD1122, 4'hF, 1'b0});
        repeat (3) @(negedge clk);
        chk("hold beat later", {data_out, keep_out, last_out}, {32'hCCDD1122, 4'hF, 1'b0});
        chk("hold ready_in", ready_in, 0);
        @(posedge clk);
        #1;
        bp_mode = 0;
        wait fork;
        wait_drain("hold");

        // reset in the middle of a packet
        ignore = 1'b1;
        bp_mode = 2;
        @(posedge clk);
        #1;
        send_beat(32'h01020304, 4'hF, 1'b0, 2'd1);
        send_beat(32'h05060708, 4'hF, 1'b0, 2'd1);
        chk("pre-reset valids", {valid_hdr, valid_out}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-reset valid_out", valid_out, 0);
        chk("mid-reset valid_hdr", valid_hdr, 0);
        chk("mid-reset last_out", last_out, 0);
        exp_pay.delete();
        exp_hdr.delete();
        bp_mode = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        ignore = 1'b0;
        run_vec(vt[0], 100);

        bp_mode = 1;
        for (int i = 0; i < 200; i++) rand_pkt();
        wait_drain("random");
        bp_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
